// File: rtl/spec_pkg.sv
// Shared types and constants for the speculative issue / squash block.
package spec_pkg;

    localparam int TAG_W = 4;
    localparam logic [TAG_W-1:0] TAG_NONE = '0;
    localparam logic [TAG_W-1:0] TAG_MAX  = 4'd15;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_e;

    // Tag 0 means "non-speculative", so the counter skips it on wrap.
    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
        return (t == TAG_MAX) ? TAG_W'(1) : t + TAG_W'(1);
    endfunction

endpackage

// File: rtl/spec_tag_fifo.sv
// Age-ordered circular FIFO of outstanding speculation tags.
module spec_tag_fifo
    import spec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic                       pop,
    output logic [TAG_W-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/spec_squash_issuer.sv
// Issues tagged speculative words and broadcasts outstanding tags on a misprediction.
module spec_squash_issuer
    import spec_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [DW-1:0]          issue_data,
    output logic                   issue_ready,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    output logic [TAG_W-1:0]       out_tag,
    input  logic                   res_valid,
    input  logic                   res_mispredict,
    output logic                   l_valid,
    output logic [TAG_W-1:0]       l_status,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   res_err,
    output state_e                 dbg_state
);

    state_e           state;
    logic [TAG_W-1:0] tag_ctr;
    logic [TAG_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             accept;

    // Handshake: a word transfers on any cycle where issue_valid && issue_ready;
    // issue_ready depends only on registered state, never on issue_valid or res_*.
    assign issue_ready = (state == RUN) && !fifo_full;
    assign accept      = issue_valid && issue_ready;
    assign dbg_state   = state;

    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            RUN:     fifo_pop = res_valid && !fifo_empty;
            SQUASH:  fifo_pop = !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    spec_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_tag (tag_ctr),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (outstanding),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            tag_ctr   <= TAG_W'(1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= TAG_NONE;
            l_valid   <= 1'b0;
            l_status  <= TAG_NONE;
            res_err   <= 1'b0;
        end else begin
            out_valid <= accept;
            out_data  <= accept ? issue_data : '0;
            out_tag   <= accept ? tag_ctr : TAG_NONE;
            if (accept) begin
                tag_ctr <= next_tag(tag_ctr);
            end

            l_valid  <= 1'b0;
            l_status <= TAG_NONE;
            case (state)
                RUN: begin
                    if (res_valid) begin
                        if (fifo_empty) begin
                            res_err <= 1'b1;
                        end else if (res_mispredict) begin
                            state    <= SQUASH;
                            l_valid  <= 1'b1;
                            l_status <= fifo_head;
                        end
                    end
                end
                SQUASH: begin
                    if (res_valid) begin
                        res_err <= 1'b1;
                    end
                    // Entries pushed alongside the mispredict are younger and get walked too.
                    if (!fifo_empty) begin
                        l_valid  <= 1'b1;
                        l_status <= fifo_head;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/spec_squash_issuer.md
Name: spec_squash_issuer

Overview:
- Producer end of the speculative-data / misspeculation-status interface.
- Issues speculative data words, each stamped with a 4-bit speculation tag, and tracks outstanding tags in age order.
- When a misprediction resolves, walks the outstanding tags and broadcasts each one on l_valid/l_status, so downstream holders of tagged speculative data squash it and non-speculative holders commit.

Parameters:
DW, 8, width of the speculative data word
DEPTH, 4, max outstanding speculative tags; power of two, 2..8

Ports:
clk  in  1  clock, all ports labelled {L}
rst  in  1  synchronous active-high reset
issue_valid  in  1  request to issue a speculative word
issue_data  in  DW  speculative data
issue_ready  out  1  issue accepted when issue_valid && issue_ready
out_valid  out  1  tagged speculative word valid (one-cycle pulse)
out_data  out  DW  speculative data to downstream
out_tag  out  4  speculation tag of out_data
res_valid  in  1  resolution of the oldest outstanding tag
res_mispredict  in  1  qualifies res_valid: 1 = misspeculated, 0 = correct
l_valid  out  1  squash broadcast valid
l_status  out  4  tag being squashed
outstanding  out  $clog2(DEPTH)+1  number of live tags
res_err  out  1  sticky: resolution arrived with nothing to resolve or during squash

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values:
  - all outputs 0; issue_ready follows its equation below.
  - Tag FIFO empty; state RUN; tag counter = 1.
- Tags:
  - 4 bits, values 1..15. Tag 0 (TAG_NONE) is reserved as "non-speculative / already squashed" and is never issued.
  - Counter advances on each accepted issue and wraps 15 -> 1.
  - Counter is not rewound on squash. This avoids aliasing with tags still held downstream.
- issue_ready = (state == RUN) && (outstanding < DEPTH). It is purely registered-state based, with no combinational path from res_*.
- Accepted issue at cycle N:
  - Tag is pushed to the FIFO tail.
  - Cycle N+1: out_valid = 1, out_data = issue_data, out_tag = the tag.
- res_valid && !res_mispredict in RUN with FIFO non-empty: pop head. No broadcast.
- res_valid && res_mispredict in RUN with FIFO non-empty at cycle N:
  - Enter SQUASH.
  - Cycle N+1: l_valid = 1, l_status = head tag, and the head is popped.
  - Each following cycle broadcasts and pops the next-oldest tag, one per cycle.
  - The cycle after the last pulse, l_valid = 0 and state returns to RUN.
- l_valid and l_status are registered. l_status = 0 whenever l_valid = 0.
- Simultaneous events:
  - Issue accepted in the mispredict cycle: the new entry is younger and is included in the squash walk.
  - Issue and correct-resolve in the same cycle: push and pop both occur; outstanding is unchanged.
  - Correct-resolve when full: the pop frees the slot next cycle, not the same cycle.
- Error cases:
  - res_valid with FIFO empty, or any res_valid during SQUASH: ignored, and res_err is set.
  - res_err clears only on rst.
- rst mid-squash: walk is abandoned; FIFO is emptied; l_valid = 0 the next cycle; tag counter = 1.
- outstanding counts the live entries after the current cycle's push and pop.

Decomposition:
- Package spec_pkg:
  - TAG_W = 4, TAG_NONE = 0, TAG_MAX = 15.
  - State enum {RUN, SQUASH}.
  - Function next_tag(t): implements the 15 -> 1 wrap.
- One sub-module, spec_tag_fifo:
  - DEPTH x 4-bit circular FIFO with push, pop, head, count, full and empty.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Top-level spec_squash_issuer holds the FSM, tag counter, output registers and res_err.

Test Plan:
- Reset, then issue 3 words 0xA1, 0xA2, 0xA3 -> out_tag 1, 2, 3 one cycle after each accept; outstanding = 3; l_valid never asserted.
- Outstanding tags 1..3; res_valid with mispredict = 0 twice, then mispredict = 1 -> l_valid pulse with l_status = 3 only; back in RUN next cycle; issue_ready = 1; next issue gets tag 4.
- Fill to DEPTH = 4 (tags 1..4) -> issue_ready = 0. Mispredict -> l_status 1, 2, 3, 4 on four consecutive cycles; issue_ready = 0 throughout; outstanding = 0 afterwards.
- Issue 15 words, each resolved correct -> tags 1..15, and the 16th issue gets tag 1; tag 0 is never seen on out_tag.
- Mispredict together with an accepted issue (tags 5 and 6 outstanding, new tag 7) -> broadcasts 5, 6, 7. A res_valid during the walk sets res_err = 1 and the walk is unchanged.
- Assert rst during the second cycle of a 4-tag squash -> l_valid = 0 next cycle; outstanding = 0; res_err = 0; next issue gets tag 1.
